// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: bridges single LSU doubleword accesses onto a valid/ready memory bus.
// Define LSU_LINE_BUFFER_EN to add a one-entry load line buffer that serves repeat loads.
`ifndef XLEN
`define XLEN 64
`endif

package basic_cache_params;
    localparam int aligned_addr_size = 29;
endpackage

module lsu_bus_adapter
    import basic_cache_params::*;
#(
    parameter logic [aligned_addr_size-1:0] BASE_ADDR  = '0,
    parameter logic [aligned_addr_size-1:0] LIMIT_ADDR = '1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lsu_prev_stalled,
    input  logic [aligned_addr_size-1:0] lsu_addr,
    input  logic                         lsu_do_load,
    input  logic                         lsu_do_store,
    input  logic [`XLEN-1:0]             lsu_store_data,
    input  logic [`XLEN/8-1:0]           lsu_store_mask,
    output logic                         lsu_stall_next,
    output logic [`XLEN-1:0]             lsu_load_data,
    output logic                         lsu_access_fault,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [aligned_addr_size-1:0] mem_req_addr,
    output logic                         mem_req_write,
    output logic [`XLEN-1:0]             mem_req_wdata,
    output logic [`XLEN/8-1:0]           mem_req_wmask,
    input  logic                         mem_resp_valid,
    input  logic [`XLEN-1:0]             mem_resp_data,
    input  logic                         mem_resp_error
);

    localparam int AW = aligned_addr_size;
    localparam int XL = `XLEN;
    localparam int MW = `XLEN / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] req_addr;
    logic          req_store;
    logic [XL-1:0] req_wdata;
    logic [MW-1:0] req_wmask;

    logic accept;
    logic below_base;
    logic above_limit;
    logic in_range;
    logic resp_take;
    logic lb_hit;
    logic [XL-1:0] lb_rdata;

    // Full-range bounds collapse to constants so no always-true compare is built.
    generate
        if (BASE_ADDR == '0) begin : g_no_base
            assign below_base = 1'b0;
        end else begin : g_base
            assign below_base = lsu_addr < BASE_ADDR;
        end
        if (LIMIT_ADDR == '1) begin : g_no_limit
            assign above_limit = 1'b0;
        end else begin : g_limit
            assign above_limit = lsu_addr > LIMIT_ADDR;
        end
    endgenerate

    assign in_range  = !below_base && !above_limit;
    assign accept    = (state == IDLE) && !lsu_prev_stalled
                     && (lsu_do_load || lsu_do_store);
    assign resp_take = (state == RESP) && mem_resp_valid;

    function automatic logic [XL-1:0] merge_bytes(
        input logic [XL-1:0] old_data,
        input logic [XL-1:0] new_data,
        input logic [MW-1:0] mask
    );
        logic [XL-1:0] res;
        res = old_data;
        for (int b = 0; b < MW; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return res;
    endfunction

`ifdef LSU_LINE_BUFFER_EN
    logic          lb_valid;
    logic [AW-1:0] lb_tag;
    logic [XL-1:0] lb_data;
    logic          lb_tag_match;

    assign lb_tag_match = lb_valid && (lb_tag == req_addr);
    assign lb_hit   = lb_valid && !lsu_do_store && (lb_tag == lsu_addr);
    assign lb_rdata = lb_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            lb_valid <= 1'b0;
        end else if (resp_take) begin
            if (mem_resp_error) begin
                lb_valid <= 1'b0;
            end else if (!req_store) begin
                lb_valid <= 1'b1;
            end
        end
    end

    // Stores only touch the entry when it already holds the same line.
    always_ff @(posedge clk) begin
        if (resp_take && !mem_resp_error) begin
            if (!req_store) begin
                lb_tag  <= req_addr;
                lb_data <= mem_resp_data;
            end else if (lb_tag_match) begin
                lb_data <= merge_bytes(lb_data, req_wdata, req_wmask);
            end
        end
    end
`else
    assign lb_hit   = 1'b0;
    assign lb_rdata = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lsu_access_fault <= 1'b0;
            lsu_load_data    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            state            <= DONE;
                            lsu_access_fault <= 1'b1;
                            lsu_load_data    <= '0;
                        end else if (lb_hit) begin
                            state            <= DONE;
                            lsu_access_fault <= 1'b0;
                            lsu_load_data    <= lb_rdata;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        state            <= DONE;
                        lsu_access_fault <= mem_resp_error;
                        lsu_load_data    <= req_store ? '0 : mem_resp_data;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request payload is captured once and held for the whole bus exchange.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= lsu_addr;
            req_store <= lsu_do_store;
            req_wdata <= lsu_store_data;
            req_wmask <= lsu_store_mask;
        end
    end

    assign lsu_stall_next = (state != DONE);
    assign mem_req_valid  = (state == REQ);
    assign mem_req_addr   = req_addr;
    assign mem_req_write  = req_store;
    assign mem_req_wdata  = req_wdata;
    assign mem_req_wmask  = req_wmask;

endmodule
